// File: rtl/pc_fetch_unit.sv
// Program-counter and fetch sequencer.
// Selects the next fetch address from PCsrc/ImmOp, halts on a repeated
// branch-to-self, and keeps saturating retired/taken-branch counters.
module pc_fetch_unit #(
  parameter int ADDR_LEN    = 8,
  parameter int INSTR_STEP  = 4,
  parameter int HALT_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                PCsrc,
  input  logic [ADDR_LEN-1:0] ImmOp,
  input  logic                resume,
  output logic [ADDR_LEN-1:0] PC,
  output logic                fetch_valid,
  output logic                halted,
  output logic [CNT_W-1:0]    instr_cnt,
  output logic [CNT_W-1:0]    branch_cnt
);

  localparam int LOOP_W = $clog2(HALT_THRESH + 1);

  localparam logic [1:0] ST_FLUSH = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [ADDR_LEN-1:0] STEP     = ADDR_LEN'(INSTR_STEP);
  localparam logic [LOOP_W-1:0]   THRESH   = LOOP_W'(HALT_THRESH);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  logic [1:0]          state;
  logic [LOOP_W-1:0]   loop_cnt;
  logic [LOOP_W-1:0]   loop_nxt;
  logic [ADDR_LEN-1:0] pc_seq;
  logic [ADDR_LEN-1:0] pc_br;
  logic                self_br;

  // Next-PC candidates and branch-to-self run length
  always_comb begin
    pc_seq   = PC + STEP;
    pc_br    = PC + ImmOp;
    self_br  = PCsrc && (ImmOp == '0);
    loop_nxt = self_br ? loop_cnt + LOOP_W'(1) : '0;
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    fetch_valid = (state == ST_RUN);
    halted      = (state == ST_HALT);
  end

  // Sequencer: FLUSH -> RUN, RUN -> HALT on repeated self-branch, HALT -> RUN on resume
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_FLUSH;
      PC         <= '0;
      loop_cnt   <= '0;
      instr_cnt  <= '0;
      branch_cnt <= '0;
    end else begin
      case (state)
        ST_FLUSH: state <= ST_RUN;
        ST_RUN: begin
          if (en) begin
            PC       <= PCsrc ? pc_br : pc_seq;
            loop_cnt <= loop_nxt;
            if (instr_cnt != CNT_MAX)
              instr_cnt <= instr_cnt + CNT_W'(1);
            if (PCsrc && (branch_cnt != CNT_MAX))
              branch_cnt <= branch_cnt + CNT_W'(1);
            if (self_br && (loop_nxt == THRESH))
              state <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (resume) begin
            state    <= ST_RUN;
            PC       <= pc_seq;
            loop_cnt <= '0;
          end
        end
        default: state <= ST_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver steps a behavioural model and
// queues the expected post-edge outputs; a monitor compares after each edge.
module tb_pc_fetch_unit;

  localparam int AW    = 8;
  localparam int CW    = 6;
  localparam int STEPB = 4;
  localparam int THR   = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          PCsrc = 1'b0;
  logic [AW-1:0] ImmOp = '0;
  logic          resume = 1'b0;
  logic [AW-1:0] PC;
  logic          fetch_valid;
  logic          halted;
  logic [CW-1:0] instr_cnt;
  logic [CW-1:0] branch_cnt;

  pc_fetch_unit #(
    .ADDR_LEN(AW), .INSTR_STEP(STEPB), .HALT_THRESH(THR), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .PCsrc(PCsrc), .ImmOp(ImmOp),
    .resume(resume), .PC(PC), .fetch_valid(fetch_valid), .halted(halted),
    .instr_cnt(instr_cnt), .branch_cnt(branch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int fv;
    int hl;
    int ic;
    int bc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // behavioural model
  bit m_flush, m_halt;
  int m_pc, m_loop, m_ic, m_bc;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_flush = 1; m_halt = 0; m_pc = 0; m_loop = 0; m_ic = 0; m_bc = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pc = m_pc;
    e.fv = (!m_flush && !m_halt) ? 1 : 0;
    e.hl = m_halt ? 1 : 0;
    e.ic = m_ic;
    e.bc = m_bc;
    return e;
  endfunction

  // One clock of the programmer-visible rules
  task automatic model_step(input bit e, input bit p, input int imm, input bit r);
    if (m_flush) begin
      m_flush = 0;
    end else if (m_halt) begin
      if (r) begin
        m_halt = 0;
        m_pc = (m_pc + STEPB) % (1 << AW);
        m_loop = 0;
      end
    end else if (e) begin
      m_pc = (m_pc + (p ? imm : STEPB)) % (1 << AW);
      if (m_ic < CMAX) m_ic++;
      if (p && m_bc < CMAX) m_bc++;
      if (p && imm == 0) begin
        m_loop++;
        if (m_loop == THR) m_halt = 1;
      end else begin
        m_loop = 0;
      end
    end
  endtask

  // Called at a negedge: drive inputs, advance model, queue expectation
  task automatic drive_step(input bit e, input bit p, input int imm, input bit r);
    en = e; PCsrc = p; ImmOp = AW'(imm); resume = r;
    model_step(e, p, imm, r);
    exp_q.push_back(model_out());
  endtask

  task automatic cyc(input bit e, input bit p, input int imm, input bit r);
    @(negedge clk);
    drive_step(e, p, imm, r);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_pc", int'(PC), 0);
    chk("async_rst_fv", int'(fetch_valid), 0);
    chk("async_rst_halted", int'(halted), 0);
    model_reset();
    exp_q.push_back(model_out());
    @(negedge clk);
    rst = 1'b1;
    drive_step(1, 0, 0, 0);
  endtask

  // Monitor: compare after each active edge whenever an expectation is queued
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        chk("pc", int'(PC), x.pc);
        chk("fetch_valid", int'(fetch_valid), x.fv);
        chk("halted", int'(halted), x.hl);
        chk("instr_cnt", int'(instr_cnt), x.ic);
        chk("branch_cnt", int'(branch_cnt), x.bc);
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    #3;
    chk("reset_pc", int'(PC), 0);
    chk("reset_fv", int'(fetch_valid), 0);
    chk("reset_halted", int'(halted), 0);
    chk("reset_icnt", int'(instr_cnt), 0);
    chk("reset_bcnt", int'(branch_cnt), 0);

    // sequential fetch out of FLUSH
    @(negedge clk);
    rst = 1'b1;
    drive_step(1, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0);
    // resume outside HALT is ignored; stall holds
    cyc(1, 0, 0, 1);
    repeat (2) cyc(0, 1, 8, 0);
    // backward branch to 0
    cyc(1, 1, (8 - m_pc) & 255, 0);
    cyc(1, 1, 248, 0);
    // PC=4, ImmOp=-8 wraps to 252
    cyc(1, 1, (4 - m_pc) & 255, 0);
    cyc(1, 1, 248, 0);
    // move to 12, then self-branch until halt
    cyc(1, 1, (12 - m_pc) & 255, 0);
    repeat (3) cyc(1, 1, 0, 0);
    // HALT ignores en/PCsrc/ImmOp, then resume wins over en
    repeat (2) cyc(1, 1, 20, 0);
    cyc(1, 1, 20, 1);
    // two self-branches, stall 4, sequential clears the run
    repeat (2) cyc(1, 1, 0, 0);
    repeat (4) cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    // wrap 252 -> 0, then async reset mid-cycle
    cyc(1, 1, (252 - m_pc) & 255, 0);
    cyc(1, 0, 0, 0);
    mid_reset();

    // randomized phase, long enough to saturate the counters
    for (int i = 0; i < 600; i++) begin
      bit e, p, r;
      int imm;
      e   = ($urandom_range(0, 9) < 8);
      p   = ($urandom_range(0, 1) == 1);
      imm = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 255));
      r   = ($urandom_range(0, 4) == 0);
      if (i == 300) mid_reset();
      else cyc(e, p, imm, r);
    end
    // saturation: ensure both counters pinned at max
    repeat (2 * CMAX) cyc(1, 1, 4, 0);
    repeat (5) cyc(1, 1, 4, 1);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
